// File: rtl/vision_reset_sequencer.sv
// Staged release of NUM_STAGES downstream resets once the PLL is locked.
// Define VISION_RSTSEQ_TIMEOUT_EN to build the ready timeout and the sticky ERROR state.
module vision_reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int DELAY_CYCLES   = 1024,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  fabric_reset_n,
  input  logic                  pll_lock,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] err_stage
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int DLY_W = $clog2(DELAY_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("NUM_STAGES must be in 1..8");
  end
  if (DELAY_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_counts
    $error("DELAY_CYCLES and TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    WAIT_LOCK,
    DELAY,
    WAIT_READY,
    DONE,
    ERROR
  } state_t;

  // NOTE: reset asserts asynchronously but deasserts on clk, so no flop sees a
  // release edge close to its clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge fabric_reset_n) begin
    if (!fabric_reset_n) rst_pipe <= 2'b00;
    else                 rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic                  plock_meta, plock_s;
  logic [NUM_STAGES-1:0] rdy_meta, rdy_s;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plock_meta <= 1'b0;
      plock_s    <= 1'b0;
      rdy_meta   <= '0;
      rdy_s      <= '0;
    end else begin
      plock_meta <= pll_lock;
      plock_s    <= plock_meta;
      rdy_meta   <= stage_ready;
      rdy_s      <= rdy_meta;
    end
  end

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  abort;

`ifdef VISION_RSTSEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] to_q, to_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] es_q, es_d;
`endif

  // Lock loss and soft request have the same effect, so their relative priority
  // collapses into one abort term.
  assign abort = !plock_s || soft_rst_req;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    rst_d   = rst_q;
`ifdef VISION_RSTSEQ_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
    es_d    = es_q;
`endif
    if (state_q != ERROR && abort) begin
      state_d = WAIT_LOCK;
      idx_d   = '0;
      dly_d   = '0;
      rst_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          // Reaching here means plock_s is high and no soft request is pending.
          rst_d   = '0;
          idx_d   = '0;
          dly_d   = '0;
          state_d = DELAY;
        end
        DELAY: begin
          if (dly_q == DLY_LAST) begin
            rst_d[idx_q] = 1'b1;
            state_d      = WAIT_READY;
`ifdef VISION_RSTSEQ_TIMEOUT_EN
            to_d         = '0;
`endif
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        WAIT_READY: begin
          if (rdy_s[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              dly_d   = '0;
              state_d = DELAY;
            end
          end
`ifdef VISION_RSTSEQ_TIMEOUT_EN
          else if (to_q == TMO_LAST) begin
            state_d = ERROR;
            rst_d   = '0;
            err_d   = 1'b1;
            es_d    = idx_q;
          end else begin
            to_d = to_q + 1'b1;
          end
`endif
        end
        DONE: ;
        ERROR: begin
          rst_d = '0;
`ifdef VISION_RSTSEQ_TIMEOUT_EN
          if (soft_rst_req) begin
            state_d = WAIT_LOCK;
            idx_d   = '0;
            err_d   = 1'b0;
            es_d    = '0;
          end
`else
          state_d = WAIT_LOCK;
`endif
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      idx_q   <= '0;
      dly_q   <= '0;
      rst_q   <= '0;
`ifdef VISION_RSTSEQ_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
      es_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      rst_q   <= rst_d;
`ifdef VISION_RSTSEQ_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
      es_q    <= es_d;
`endif
    end
  end

  assign stage_reset_n = rst_q;
  assign seq_done      = (state_q == DONE);
`ifdef VISION_RSTSEQ_TIMEOUT_EN
  assign seq_error     = err_q;
  assign err_stage     = es_q;
`else
  assign seq_error     = 1'b0;
  assign err_stage     = '0;
`endif

endmodule

// File: tb/tb_vision_reset_sequencer.sv
// Self-checking bench for vision_reset_sequencer: expected output timelines are derived
// from release/ready/timeout edge arithmetic, with randomized ready latencies.
module tb_vision_reset_sequencer;

  localparam int NS  = 4;
  localparam int DLY = 16;
  localparam int TMO = 64;
`ifdef VISION_RSTSEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          fabric_reset_n;
  logic          pll_lock;
  logic          soft_rst_req;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_reset_n;
  logic          seq_done;
  logic          seq_error;
  logic [1:0]    err_stage;

  int e      = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vision_reset_sequencer #(
    .NUM_STAGES    (NS),
    .DELAY_CYCLES  (DLY),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .fabric_reset_n(fabric_reset_n),
    .pll_lock      (pll_lock),
    .soft_rst_req  (soft_rst_req),
    .stage_ready   (stage_ready),
    .stage_reset_n (stage_reset_n),
    .seq_done      (seq_done),
    .seq_error     (seq_error),
    .err_stage     (err_stage)
  );

  // e counts clock edges; inputs are driven and outputs sampled 1 time unit after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h, expected %0h", tag, e, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [NS-1:0] rst, input logic done,
                               input logic err, input logic [1:0] es);
    check({tag, ".stage_reset_n"}, 32'(stage_reset_n), 32'(rst));
    check({tag, ".seq_done"},      32'(seq_done),      32'(done));
    check({tag, ".seq_error"},     32'(seq_error),     32'(err));
    check({tag, ".err_stage"},     32'(err_stage),     32'(es));
  endtask

  // One sequencing pass starting with DELAY entered at edge t0. d[s] is the number of
  // edges after stage s's release at which its ready input is raised.
  // stop_kind 1: soft request in the cycle rdy_s[stop_stage] rises (abort must win).
  // stop_kind 2: async reset 5 edges into the DELAY of stop_stage.
  task automatic run_seq(input string tag, input int t0, input int d[NS], input int stop_kind,
                         input int stop_stage, output int end_e, output bit got_err);
    int r[NS];
    int rdy_at[NS];
    int last   = -1;
    int err_e  = -1;
    int err_s  = 0;
    int done_e = -1;
    int stop_e = -1;
    int t      = t0;
    int cut;
    logic [NS-1:0] exp_rst;
    logic          exp_err;
    for (int s = 0; s < NS; s++) begin
      r[s]      = t + DLY;
      rdy_at[s] = r[s] + d[s];
      last      = s;
      // rdy_s is first high after edge rdy_at+2; it must be seen before the edge r+TMO.
      if (TMO_EN && d[s] + 2 > TMO - 1) begin
        err_e = r[s] + TMO;
        err_s = s;
        break;
      end
      if (stop_kind == 1 && s == stop_stage) begin
        stop_e = rdy_at[s] + 3;
        break;
      end
      t = rdy_at[s] + 3;
      if (stop_kind == 2 && s + 1 == stop_stage) begin
        stop_e = t + 5;
        break;
      end
      if (s == NS - 1) done_e = t;
    end
    if (err_e >= 0)       end_e = err_e + 4;
    else if (stop_e >= 0) end_e = stop_e;
    else                  end_e = done_e + 4;
    if (err_e >= 0)                          cut = err_e;
    else if (stop_kind == 1 && stop_e >= 0) cut = stop_e;
    else                                     cut = 32'h7fff_ffff;

    while (e < end_e) begin
      tick();
      for (int s = 0; s <= last; s++)
        if (e == rdy_at[s]) stage_ready[s] = 1'b1;
      if (stop_kind == 1 && stop_e >= 0 && e == stop_e - 1) begin
        soft_rst_req = 1'b1;
        stage_ready  = '0;
      end
      if (stop_kind == 1 && e == stop_e) soft_rst_req = 1'b0;
      exp_rst = '0;
      for (int s = 0; s <= last; s++)
        exp_rst[s] = (e >= r[s]) && (e < cut);
      exp_err = (err_e >= 0) && (e >= err_e);
      check_outputs(tag, exp_rst, (done_e >= 0) && (e >= done_e), exp_err,
                    exp_err ? 2'(err_s) : 2'd0);
      if (stop_kind == 2 && stop_e >= 0 && e == stop_e) begin
        fabric_reset_n = 1'b0;
        #1;
        check_outputs({tag, ".async"}, '0, 1'b0, 1'b0, 2'd0);
      end
    end
    got_err = (err_e >= 0);
  endtask

  task automatic soft_restart(input string tag, output int t0);
    soft_rst_req = 1'b1;
    stage_ready  = '0;
    tick();
    soft_rst_req = 1'b0;
    check_outputs(tag, '0, 1'b0, 1'b0, 2'd0);
    t0 = e + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, expected $finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int end_e;
    bit got_err;
    int dv[NS];

    fabric_reset_n = 1'b0;
    pll_lock       = 1'b0;
    soft_rst_req   = 1'b0;
    stage_ready    = '0;
    repeat (3) tick();
    check_outputs("reset_hold", '0, 1'b0, 1'b0, 2'd0);

    fabric_reset_n = 1'b1;
    repeat (4) tick();
    check_outputs("no_lock", '0, 1'b0, 1'b0, 2'd0);

    // Nominal: every stage ready 5 edges after its release.
    pll_lock = 1'b1;
    t0       = e + 3;
    dv       = '{5, 5, 5, 5};
    run_seq("nominal", t0, dv, 0, 0, end_e, got_err);

    stage_ready[1] = 1'b0;
    repeat (4) tick();
    check_outputs("done_ready_drop", '1, 1'b1, 1'b0, 2'd0);

    // Lock loss in DONE: outputs fall on the third edge.
    pll_lock    = 1'b0;
    stage_ready = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_outputs("lock_loss", {NS{k < 3}}, k < 3, 1'b0, 2'd0);
    end
    repeat (2) tick();
    pll_lock = 1'b1;
    t0       = e + 3;
    for (int s = 0; s < NS; s++) dv[s] = $urandom_range(0, 20);
    run_seq("relock", t0, dv, 0, 0, end_e, got_err);

    // Soft request coinciding with rdy_s[1]; the following run proves idx restarted at 0.
    soft_restart("soft_in_done", t0);
    for (int s = 0; s < NS; s++) dv[s] = $urandom_range(0, 20);
    run_seq("simultaneous", t0, dv, 1, 1, end_e, got_err);
    t0 = end_e + 1;
    dv[0] = TMO - 3;
    for (int s = 1; s < NS; s++) dv[s] = $urandom_range(0, 20);
    run_seq("ready_at_limit", t0, dv, 0, 0, end_e, got_err);

    // Stage 2 stalls one edge past the last acceptable ready.
    soft_restart("soft_2", t0);
    for (int s = 0; s < NS; s++) dv[s] = $urandom_range(0, 20);
    dv[2] = TMO - 2;
    run_seq("stall_stage2", t0, dv, 0, 0, end_e, got_err);
    if (got_err) begin
      pll_lock = 1'b0;
      repeat (6) tick();
      check_outputs("error_ignores_lock", '0, 1'b0, 1'b1, 2'd2);
      pll_lock = 1'b1;
      repeat (3) tick();
    end
    soft_restart("soft_clears_error", t0);

    // Stage 0 silent for 1000 edges: timeout at stage 0, or an indefinite wait.
    dv[0] = 1000;
    for (int s = 1; s < NS; s++) dv[s] = $urandom_range(0, 20);
    run_seq("stall_stage0", t0, dv, 0, 0, end_e, got_err);
    soft_restart("soft_3", t0);

    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < NS; s++) dv[s] = $urandom_range(0, TMO + 6);
      run_seq("random", t0, dv, 0, 0, end_e, got_err);
      soft_restart("soft_random", t0);
    end

    // Async reset in the DELAY phase of stage 3.
    for (int s = 0; s < NS; s++) dv[s] = $urandom_range(0, 20);
    run_seq("async_reset", t0, dv, 2, 3, end_e, got_err);
    repeat (2) tick();
    check_outputs("reset_reheld", '0, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vision_reset_sequencer.md
# vision_reset_sequencer

Staged reset release for the vision pipeline, fed directly by the PolarFire reset core's FABRIC_RESET_N output. After PLL lock, it releases NUM_STAGES downstream resets in fixed order (stage 0 first: sensor I/F, MIPI RX, processing pipeline, display), one at a time. Each release waits a fixed delay, then waits for that stage's ready acknowledgement. Loss of lock, a soft request or a stalled stage drops every stage back into reset.

## Interface
- NUM_STAGES, 4: number of sequenced reset outputs (1..8).
- DELAY_CYCLES, 1024: cycles between sequencing decisions and each stage release (≥2).
- TIMEOUT_CYCLES, 65536: maximum cycles to wait for STAGE_READY after a release (≥2).
- CLK  in  1  single clock; all logic in this domain.
- FABRIC_RESET_N  in  1  reset, asynchronous, active-low (assertion async, deassertion taken on CLK via 2-flop synchroniser).
- PLL_LOCK  in  1  asynchronous; 2-flop synchronised (plock_s).
- SOFT_RST_REQ  in  1  synchronous single-cycle pulse from control registers.
- STAGE_READY  in  NUM_STAGES  asynchronous per-stage ready; each bit 2-flop synchronised (rdy_s).
- STAGE_RESET_N  out  NUM_STAGES  per-stage active-low reset, registered.
- SEQ_DONE  out  1  all stages released and ready.
- SEQ_ERROR  out  1  sticky timeout flag.
- ERR_STAGE  out  $clog2(NUM_STAGES) (min 1)  index of stage that timed out.

## Operation
- Reset values: STAGE_RESET_N all 0, SEQ_DONE 0, SEQ_ERROR 0, ERR_STAGE 0, state WAIT_LOCK, idx 0, counters 0.
- WAIT_LOCK: all STAGE_RESET_N 0. On plock_s=1 → DELAY, idx=0, delay counter loaded.
- DELAY: count DELAY_CYCLES; on expiry set STAGE_RESET_N[idx]=1 → WAIT_READY, timeout counter cleared.
- WAIT_READY: rdy_s[idx]=1 → if idx=NUM_STAGES-1 → DONE, else idx+1 → DELAY. Timeout expiry → ERROR, ERR_STAGE=idx.
- DONE: SEQ_DONE=1; released resets stay 1. A ready bit dropping later is ignored.
- ERROR: all STAGE_RESET_N 0, SEQ_ERROR=1. Exit only on SOFT_RST_REQ (clears SEQ_ERROR and ERR_STAGE, → WAIT_LOCK) or FABRIC_RESET_N. Lock loss is ignored in ERROR.
- Abort (any state except ERROR): plock_s=0 or SOFT_RST_REQ=1 → next edge all STAGE_RESET_N 0, SEQ_DONE 0, idx 0, → WAIT_LOCK.
- Abort in WAIT_LOCK with plock_s=1 and SOFT_RST_REQ=1: SOFT_RST_REQ wins, remains in WAIT_LOCK one cycle.
- Priority, same cycle: lock loss > SOFT_RST_REQ > ready > timeout.
- Already-released stages stay released while later stages sequence.
- Counters saturate; no wrap.

## Timing
- Synchroniser latency: 2 CLK edges on PLL_LOCK and STAGE_READY.
- Entering DELAY at edge t: STAGE_RESET_N[idx] rises at edge t+DELAY_CYCLES.
- Release at edge r:
  - if rdy_s[idx] is first sampled 1 in the cycle after r, the next state is taken at r+1;
  - timeout → ERROR at edge r+TIMEOUT_CYCLES if rdy_s[idx] was never 1.
- SEQ_DONE rises one edge after the last stage's rdy_s is sampled 1.
- Abort: outputs fall one edge after the abort condition is sampled (after synchroniser delay for lock).
- Minimum reset hold after an abort is DELAY_CYCLES+1 cycles, since every restart passes through DELAY.

## Configuration
- VISION_RSTSEQ_TIMEOUT_EN defined: timeout counter and ERROR state present, as above.
- VISION_RSTSEQ_TIMEOUT_EN undefined:
  - WAIT_READY waits indefinitely;
  - no timeout counter is built;
  - SEQ_ERROR and ERR_STAGE are tied 0.

## Test plan
All scenarios use NUM_STAGES=4, DELAY_CYCLES=16, TIMEOUT_CYCLES=64.
- Nominal: PLL_LOCK=1, each STAGE_READY returned 5 cycles after its release → STAGE_RESET_N goes 0001, 0011, 0111, 1111 with ≥16-cycle spacing; SEQ_DONE=1; SEQ_ERROR=0.
- Timeout: stage 2 never ready → ERROR at release+64, STAGE_RESET_N=0000, SEQ_ERROR=1, ERR_STAGE=2. SOFT_RST_REQ then clears SEQ_ERROR and the sequence restarts.
- Lock loss: PLL_LOCK drops in DONE → STAGE_RESET_N=0000 and SEQ_DONE=0 three edges later; re-lock → full resequence.
- Simultaneous: SOFT_RST_REQ pulse in the same cycle that rdy_s[1] rises → abort wins, idx=0, state WAIT_LOCK.
- Async reset: FABRIC_RESET_N asserted mid-DELAY of stage 3 → all outputs reach reset values immediately, without a clock edge.
- Macro off: stage 0 never ready for 1000 cycles → SEQ_ERROR stays 0 and STAGE_RESET_N stays 0001; asserting ready then → sequence proceeds.
